pgm_irq_ctrl: RTL and testbench
===============================

Name: pgm_irq_ctrl

Overview:
- 68000 interrupt controller for the PGM main CPU. It sits directly upstream of the fx68k IPL and VPA inputs.
- Collects asynchronous interrupt sources such as video vblank, Z80-to-68k sound reply and a timer tick. Each source is latched as a pending flag, can be masked by a register, and is priority-encoded onto IPL.
- Answers IACK cycles with VPAn so the CPU takes the autovector.
- Runs in the 68k clock domain and is mapped at a decoded register window in the C0xxxx I/O space.

Parameters:
- NUM_SRC, 3, number of interrupt sources (1..7).
- SRC_LEVELS, {3'd4,3'd2,3'd6}, packed 3 bits per source giving its IPL level (1..7); source 0 is the LSBs. Default: src0 = vblank at level 6, src1 = timer at level 2, src2 = sound at level 4.

Ports:
- clk  in  1  68k clock (fixed_20m_clk at top level).
- reset  in  1  asynchronous, active-high reset.
- src  in  NUM_SRC  raw interrupt request levels, asynchronous; rising edge triggers.
- reg_sel  in  1  CPU cycle addresses this block (decoded, includes !as_n).
- reg_we  in  1  write strobe (!rw_n), valid with reg_sel.
- reg_addr  in  1  0 = ENABLE register, 1 = PENDING register.
- reg_din  in  16  CPU write data.
- reg_dout  out  16  read data; combinational from registers.
- as_n  in  1  CPU address strobe.
- cpu_fc  in  3  CPU function code.
- iack_lvl  in  3  adr[3:1] during an IACK cycle.
- ipl_n  out  3  active-low encoded interrupt level to the CPU.
- vpa_n  out  1  active-low autovector request.
- irq_pending  out  NUM_SRC  pending flags, for debug and overlay.

Behaviour:
- Reset (async, active-high):
  - ENABLE = 0, pending = 0, synchronisers = 0.
  - ipl_n = 3'b111, vpa_n = 1, reg_dout = register contents (0).
- Synchronisation:
  - Per source, s1 <= src and s2 <= s1 form a 2-flop synchroniser; s3 <= s2 holds the previous value.
  - rise[i] = s2 & ~s3.
  - With src high before edge 1: s1 rises at edge 1, s2 at edge 2, pending set at edge 3, ipl_n updated at edge 4. Latency is 4 clocks, not shortened.
- Pending:
  - pend[i] is set on rise[i] regardless of ENABLE, and held until cleared.
  - Cleared by a PENDING write with reg_din[i] = 1 (write-1-to-clear), or by an IACK that selects source i.
  - If set and clear happen in the same cycle, set wins and pend stays 1.
  - A source held high produces only one set.
- Level encode:
  - act = pend & ENABLE[NUM_SRC-1:0].
  - lvl = max SRC_LEVELS[i] over act; 0 if act is empty.
  - ipl_n <= ~lvl, registered.
  - Clearing ENABLE removes the level one clock later; pend is kept, so the source re-asserts when re-enabled.
- Registers:
  - ENABLE reads back all 16 bits written; only bits [NUM_SRC-1:0] take effect.
  - PENDING reads {zeros, pend}.
  - Writes take effect on the clock edge where reg_sel & reg_we are both high.
  - A multi-cycle strobe repeats the write, which is idempotent.
- IACK state machine, states IDLE, ACK, WAIT_AS:
  - IDLE -> ACK when !as_n and cpu_fc == 3'b111.
  - ACK, one cycle:
    - Set vpa_n <= 0.
    - Select the lowest-index source with act[i] and SRC_LEVELS[i] == iack_lvl, and clear its pend.
    - If no source matches (spurious, e.g. cleared by software), still assert vpa_n and clear nothing.
    - Go to WAIT_AS.
  - WAIT_AS: hold vpa_n = 0 until as_n = 1, then vpa_n <= 1 and go to IDLE.
  - as_n rising while in ACK goes straight to IDLE with vpa_n = 1.
  - vpa_n is never asserted outside an IACK cycle.
  - An IACK clear and a rise on the same source in the same cycle leave pend = 1.
- Reset mid-IACK: state returns to IDLE and vpa_n = 1 immediately (asynchronous).
- Multiple sources at the same level are serviced one per IACK, lowest index first; ipl_n remains at that level until all are cleared.

Test Plan:
1. Reset, ENABLE = 3'b111, pulse src[0] high for 10 clocks -> pend = 3'b001 at edge 3, ipl_n = 3'b001 (~6) at edge 4, one set only.
2. Pending src0 (level 6) and src2 (level 4) -> ipl_n = ~6. IACK with fc = 7, iack_lvl = 6 -> vpa_n low 1 cycle after as_n falls, pend = 3'b100, ipl_n = ~4. vpa_n returns to 1 one clock after as_n rises.
3. ENABLE = 0, pulse src1 -> pend[1] = 1, ipl_n = 3'b111. Write ENABLE = 3'b010 -> ipl_n = ~2 on the next clock.
4. Write PENDING = 16'h0004 in the same cycle rise[2] fires -> pend[2] stays 1. Write PENDING = 16'h0004 later -> pend[2] = 0, ipl_n = 3'b111.
5. Spurious IACK at iack_lvl = 6 with nothing pending -> vpa_n still asserts and releases, pend unchanged at 0.
6. Assert reset while in WAIT_AS with vpa_n = 0 -> vpa_n = 1, ipl_n = 3'b111, pend = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pgm_irq_ctrl.sv
// PGM 68000 interrupt controller: latches edge-triggered sources, masks and priority-encodes
// them onto IPL, and answers IACK cycles with VPAn so the CPU takes the autovector.
module pgm_irq_ctrl #(
  parameter int                   NUM_SRC    = 3,
  parameter logic [3*NUM_SRC-1:0] SRC_LEVELS = {3'd4, 3'd2, 3'd6}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               reg_sel,
  input  logic               reg_we,
  input  logic               reg_addr,
  input  logic [15:0]        reg_din,
  output logic [15:0]        reg_dout,
  input  logic               as_n,
  input  logic [2:0]         cpu_fc,
  input  logic [2:0]         iack_lvl,
  output logic [2:0]         ipl_n,
  output logic               vpa_n,
  output logic [NUM_SRC-1:0] irq_pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_WAIT_AS = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_s1, r_s2, r_s3;
  logic [NUM_SRC-1:0] r_pend;
  logic [15:0]        r_enable;
  logic [2:0]         r_ipl_n;
  logic               r_vpa_n;
  logic [NUM_SRC-1:0] w_rise, w_act, w_wr_clr, w_iack_clr;
  logic [2:0]         w_lvl;
  logic               w_vpa_n_nxt, w_found, w_wr_en, w_wr_pend;

  assign w_wr_en   = reg_sel & reg_we & ~reg_addr;
  assign w_wr_pend = reg_sel & reg_we & reg_addr;
  assign w_rise    = r_s2 & ~r_s3;
  assign w_act     = r_pend & r_enable[NUM_SRC-1:0];
  assign w_wr_clr  = w_wr_pend ? reg_din[NUM_SRC-1:0] : {NUM_SRC{1'b0}};

  // Synchronisers, pending flags (a new rise beats any clear), ENABLE and registered IPL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= {NUM_SRC{1'b0}};
      r_s2     <= {NUM_SRC{1'b0}};
      r_s3     <= {NUM_SRC{1'b0}};
      r_pend   <= {NUM_SRC{1'b0}};
      r_enable <= 16'h0000;
      r_ipl_n  <= 3'b111;
    end else begin
      r_s1    <= src;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_pend  <= (r_pend & ~(w_wr_clr | w_iack_clr)) | w_rise;
      r_ipl_n <= ~w_lvl;
      if (w_wr_en) begin
        r_enable <= reg_din;
      end else begin
        r_enable <= r_enable;
      end
    end
  end

  // Highest level among active sources
  always_comb begin
    w_lvl = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_lvl = (w_act[i] && (SRC_LEVELS[3*i +: 3] > w_lvl)) ? SRC_LEVELS[3*i +: 3] : w_lvl;
    end
  end

  // IACK state register with the registered VPAn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_vpa_n <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_vpa_n <= w_vpa_n_nxt;
    end
  end

  // IACK next state; as_n rising in any state ends the cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = (!as_n && (cpu_fc == 3'b111)) ? ST_ACK : ST_IDLE;
      ST_ACK:     w_state_nxt = as_n ? ST_IDLE : ST_WAIT_AS;
      ST_WAIT_AS: w_state_nxt = as_n ? ST_IDLE : ST_WAIT_AS;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // IACK outputs: VPAn request and clear of the lowest-index matching source (none if spurious)
  always_comb begin
    w_vpa_n_nxt = 1'b1;
    w_iack_clr  = {NUM_SRC{1'b0}};
    w_found     = 1'b0;
    case (r_state)
      ST_ACK: begin
        w_vpa_n_nxt = as_n;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (!as_n && !w_found && w_act[i] && (SRC_LEVELS[3*i +: 3] == iack_lvl)) begin
            w_iack_clr[i] = 1'b1;
            w_found       = 1'b1;
          end else begin
            w_iack_clr[i] = w_iack_clr[i];
          end
        end
      end
      ST_WAIT_AS: w_vpa_n_nxt = as_n;
      default:    w_vpa_n_nxt = 1'b1;
    endcase
  end

  assign reg_dout    = reg_addr ? {{(16-NUM_SRC){1'b0}}, r_pend} : r_enable;
  assign ipl_n       = r_ipl_n;
  assign vpa_n       = r_vpa_n;
  assign irq_pending = r_pend;

endmodule

// File: tb/tb_pgm_irq_ctrl.sv
// Bench for pgm_irq_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a cycle-level behavioural model of the controller.
module tb_pgm_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src;
  logic        reg_sel, reg_we, reg_addr;
  logic [15:0] reg_din;
  logic [15:0] reg_dout;
  logic        as_n;
  logic [2:0]  cpu_fc, iack_lvl;
  logic [2:0]  ipl_n;
  logic        vpa_n;
  logic [2:0]  irq_pending;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int          lv[3] = '{6, 2, 4};
  logic [2:0]  h0, h1, h2;       // src sampled at the last three edges, h0 newest
  logic [15:0] m_en;
  logic [2:0]  m_pend, m_ipl;
  logic        m_vpa;
  int          m_ph;             // 0 no IACK, 1 first IACK cycle, 2 waiting for as_n

  pgm_irq_ctrl dut (
    .clk(clk), .reset(reset), .src(src), .reg_sel(reg_sel), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout), .as_n(as_n),
    .cpu_fc(cpu_fc), .iack_lvl(iack_lvl), .ipl_n(ipl_n), .vpa_n(vpa_n),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int max_lvl(input logic [2:0] act);
    int m = 0;
    for (int i = 0; i < 3; i++) if (act[i] && lv[i] > m) m = lv[i];
    return m;
  endfunction

  task automatic model_reset();
    h0 = 3'd0; h1 = 3'd0; h2 = 3'd0;
    m_en = 16'h0000; m_pend = 3'd0; m_ipl = 3'b111; m_vpa = 1'b1; m_ph = 0;
  endtask

  // advance the model across one clock edge using the inputs currently applied
  task automatic model_step();
    logic [2:0] rise, clr, act;
    bit found;
    if (reset) begin
      model_reset();
    end else begin
      rise  = h1 & ~h2;
      act   = m_pend & m_en[2:0];
      clr   = (reg_sel && reg_we && reg_addr) ? reg_din[2:0] : 3'd0;
      m_ipl = ~3'(max_lvl(act));
      found = 1'b0;
      if (m_ph == 0) begin
        if (!as_n && cpu_fc == 3'd7) m_ph = 1;
      end else if (m_ph == 1) begin
        if (as_n) begin
          m_ph = 0; m_vpa = 1'b1;
        end else begin
          m_ph = 2; m_vpa = 1'b0;
          for (int i = 0; i < 3; i++)
            if (!found && act[i] && lv[i] == int'(iack_lvl)) begin
              clr[i] = 1'b1; found = 1'b1;
            end
        end
      end else begin
        if (as_n) begin m_ph = 0; m_vpa = 1'b1; end
      end
      m_pend = (m_pend & ~clr) | rise;
      if (reg_sel && reg_we && !reg_addr) m_en = reg_din;
      h2 = h1; h1 = h0; h0 = src;
    end
  endtask

  task automatic compare_all();
    check_val("ipl_n", {29'd0, ipl_n}, {29'd0, m_ipl});
    check_val("vpa_n", {31'd0, vpa_n}, {31'd0, m_vpa});
    check_val("pending", {29'd0, irq_pending}, {29'd0, m_pend});
    check_val("reg_dout", {16'd0, reg_dout}, {16'd0, (reg_addr ? {13'd0, m_pend} : m_en)});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic a, input logic [15:0] d);
    reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_din = d;
    tick();
    reg_sel = 1'b0; reg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src = 3'd0; reg_sel = 1'b0; reg_we = 1'b0; reg_addr = 1'b0;
    reg_din = 16'h0000; as_n = 1'b1; cpu_fc = 3'd0; iack_lvl = 3'd0;
    model_reset();
    ticks(2);
    check_val("rst_ipl", {29'd0, ipl_n}, 32'h7);
    check_val("rst_vpa", {31'd0, vpa_n}, 32'h1);
    reset = 1'b0;

    // 1: single edge, latency, one set only
    wr(1'b0, 16'h0007);
    src = 3'b001;
    ticks(2);
    check_val("t1_pend_e2", {29'd0, irq_pending}, 32'h0);
    tick();
    check_val("t1_pend_e3", {29'd0, irq_pending}, 32'h1);
    check_val("t1_ipl_e3", {29'd0, ipl_n}, 32'h7);
    tick();
    check_val("t1_ipl_e4", {29'd0, ipl_n}, 32'h1);
    ticks(6);
    src = 3'b000;
    ticks(3);
    check_val("t1_pend_held", {29'd0, irq_pending}, 32'h1);

    // 2: IACK at level 6 with src0 and src2 pending
    src = 3'b100; ticks(4); src = 3'b000;
    check_val("t2_pend", {29'd0, irq_pending}, 32'h5);
    check_val("t2_ipl", {29'd0, ipl_n}, 32'h1);
    as_n = 1'b0; cpu_fc = 3'd7; iack_lvl = 3'd6;
    tick();
    check_val("t2_vpa_ack", {31'd0, vpa_n}, 32'h1);
    tick();
    check_val("t2_vpa_low", {31'd0, vpa_n}, 32'h0);
    check_val("t2_pend_clr", {29'd0, irq_pending}, 32'h4);
    tick();
    check_val("t2_ipl4", {29'd0, ipl_n}, 32'h3);
    as_n = 1'b1; cpu_fc = 3'd0;
    tick();
    check_val("t2_vpa_rel", {31'd0, vpa_n}, 32'h1);

    // 3: pending while disabled, then enable
    wr(1'b1, 16'h0007);
    wr(1'b0, 16'h0000);
    src = 3'b010; ticks(4); src = 3'b000;
    check_val("t3_pend", {29'd0, irq_pending}, 32'h2);
    check_val("t3_ipl_masked", {29'd0, ipl_n}, 32'h7);
    wr(1'b0, 16'h0002);
    tick();
    check_val("t3_ipl2", {29'd0, ipl_n}, 32'h5);

    // 4: write-1-to-clear colliding with a rise
    wr(1'b1, 16'h0007);
    src = 3'b100; ticks(2);
    reg_sel = 1'b1; reg_we = 1'b1; reg_addr = 1'b1; reg_din = 16'h0004;
    tick();
    reg_sel = 1'b0; reg_we = 1'b0;
    check_val("t4_set_wins", {29'd0, irq_pending}, 32'h4);
    src = 3'b000; ticks(2);
    wr(1'b1, 16'h0004);
    check_val("t4_cleared", {29'd0, irq_pending}, 32'h0);
    tick();
    check_val("t4_ipl", {29'd0, ipl_n}, 32'h7);

    // 5: spurious IACK
    as_n = 1'b0; cpu_fc = 3'd7; iack_lvl = 3'd6;
    ticks(2);
    check_val("t5_vpa_low", {31'd0, vpa_n}, 32'h0);
    check_val("t5_pend", {29'd0, irq_pending}, 32'h0);
    as_n = 1'b1; cpu_fc = 3'd0;
    tick();
    check_val("t5_vpa_rel", {31'd0, vpa_n}, 32'h1);

    // 6: asynchronous reset while waiting for as_n
    wr(1'b0, 16'h0007);
    src = 3'b001; ticks(4); src = 3'b000;
    as_n = 1'b0; cpu_fc = 3'd7; iack_lvl = 3'd4;
    ticks(2);
    check_val("t6_vpa_low", {31'd0, vpa_n}, 32'h0);
    check_val("t6_ipl_pre", {29'd0, ipl_n}, 32'h1);
    reset = 1'b1;
    #2;
    check_val("t6_vpa_async", {31'd0, vpa_n}, 32'h1);
    check_val("t6_ipl_async", {29'd0, ipl_n}, 32'h7);
    check_val("t6_pend_async", {29'd0, irq_pending}, 32'h0);
    model_reset();
    as_n = 1'b1; cpu_fc = 3'd0;
    tick();
    reset = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b = $urandom_range(0, 2);
        src[b] = ~src[b];
      end
      if ($urandom_range(0, 5) == 0) begin
        reg_sel = 1'b1; reg_we = 1'($urandom_range(0, 1));
        reg_addr = 1'($urandom_range(0, 1)); reg_din = 16'($urandom);
      end else begin
        reg_sel = 1'b0; reg_we = 1'($urandom_range(0, 1));
        reg_addr = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 4) == 0) as_n = ~as_n;
      cpu_fc = ($urandom_range(0, 3) != 0) ? 3'd7 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: iack_lvl = 3'd2;
        1: iack_lvl = 3'd4;
        2: iack_lvl = 3'd6;
        default: iack_lvl = 3'($urandom_range(0, 7));
      endcase
      reset = ($urandom_range(0, 499) == 0);
      tick();
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
